// File: rtl/mips_pkg.sv
// Shared P6 core definitions: MDU opcode encoding, default latencies and the
// decode helper shared by the E-stage MDU and the hazard controller.
package mips_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_md_busy_op(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div as fixed-latency
// operations with a registered busy flag, and serves mfhi/mflo reads.
module e_mdu
    import mips_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hl_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {ST_IDLE, ST_RUN} md_state_e;

    md_state_e   state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        div0_q;
    logic [31:0] p_hi_q, p_lo_q;
    logic [31:0] hi_q, lo_q;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0] q_mag, r_mag, sq, sr, uq, ur;
    logic        b_zero;

    // Signed divide runs on magnitudes so the most-negative dividend needs no
    // special case; a zero divisor is replaced by 1 and its result discarded.
    always_comb begin
        prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u   = {32'b0, a} * {32'b0, b};
        b_zero   = (b == 32'd0);
        b_nz     = b_zero ? 32'd1 : b;
        a_mag    = a[31] ? (~a + 32'd1) : a;
        b_mag    = b[31] ? (~b + 32'd1) : b;
        b_mag_nz = b_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_mag_nz;
        r_mag    = a_mag % b_mag_nz;
        sq       = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        sr       = a[31] ? (~r_mag + 32'd1) : r_mag;
        uq       = a / b_nz;
        ur       = a % b_nz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            div0_q  <= 1'b0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT: begin
                                {p_hi_q, p_lo_q} <= prod_s;
                                cnt_q   <= 4'(MULT_CYCLES);
                                div0_q  <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ST_RUN;
                            end
                            MD_MULTU: begin
                                {p_hi_q, p_lo_q} <= prod_u;
                                cnt_q   <= 4'(MULT_CYCLES);
                                div0_q  <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= ST_RUN;
                            end
                            MD_DIV: begin
                                p_hi_q  <= sr;
                                p_lo_q  <= sq;
                                cnt_q   <= 4'(DIV_CYCLES);
                                div0_q  <= b_zero;
                                busy_q  <= 1'b1;
                                state_q <= ST_RUN;
                            end
                            MD_DIVU: begin
                                p_hi_q  <= ur;
                                p_lo_q  <= uq;
                                cnt_q   <= 4'(DIV_CYCLES);
                                div0_q  <= b_zero;
                                busy_q  <= 1'b1;
                                state_q <= ST_RUN;
                            end
                            MD_MTHI: hi_q <= a;
                            MD_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (!div0_q) begin
                            hi_q <= p_hi_q;
                            lo_q <= p_lo_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        hl_out = 32'd0;
        if (op == MD_MFHI)
            hl_out = hi_q;
        else if (op == MD_MFLO)
            hl_out = lo_q;
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected {hi,lo} queued at issue, compared when
// busy drops; plus reset, MT/MF and start-while-busy scenarios.
module tb_e_mdu;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hl_out, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi, m_lo;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hl_out (hl_out),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Reference result in 64-bit arithmetic; divide by zero leaves HI/LO as they were.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        res = {m_hi, m_lo};
        case (o)
            MD_MULT:  res = 64'(sx * sy);
            MD_MULTU: res = 64'(ux * uy);
            MD_DIV:   if (y != 0) begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
            MD_DIVU:  if (y != 0) begin q = ux / uy; r = ux % uy; res = {r[31:0], q[31:0]}; end
            default:  ;
        endcase
        return res;
    endfunction

    task automatic md_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int n, input string tag);
        int cyc;
        logic [63:0] exp;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        sb_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(cyc), 64'(n));
        exp = sb_q.pop_front();
        chk({tag, " hi_lo"}, {hi, lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] x);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x;
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
        if (o == MD_MTHI) m_hi = x; else m_lo = x;
        @(negedge clk);
        chk(o == MD_MTHI ? "mthi hi" : "mtlo lo", o == MD_MTHI ? 64'(hi) : 64'(lo), 64'(x));
        chk("mt busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] busyv;
        logic [63:0] exp;
        int cyc;
        reset = 1'b1; start = 1'b0; op = MD_NONE; a = 0; b = 0;
        m_hi = 0; m_lo = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset hi_lo", {hi, lo}, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset hl_out", 64'(hl_out), 64'd0);

        // Reset in the middle of a multiply discards the pending result.
        mt(MD_MTHI, 32'h55);
        @(posedge clk); #1;
        start = 1'b1; op = MD_MULT; a = 3; b = 4;
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midreset hi_lo", {hi, lo}, 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        #1 reset = 1'b0;
        m_hi = 0; m_lo = 0;
        repeat (8) @(negedge clk);
        chk("postreset hi_lo", {hi, lo}, 64'd0);
        chk("postreset busy", 64'(busy), 64'd0);

        md_op(MD_MULT,  32'hFFFFFFFE, 32'd3, 5, "mult -2*3");
        chk("mult const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        md_op(MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, "multu");
        chk("multu const", {hi, lo}, 64'h00000002_FFFFFFFA);
        md_op(MD_DIV,   32'hFFFFFFF9, 32'd2, 10, "div -7/2");
        chk("div const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        md_op(MD_DIVU,  32'd7, 32'd2, 10, "divu 7/2");
        chk("divu const", {hi, lo}, 64'h00000001_00000003);

        mt(MD_MTHI, 32'h11);
        mt(MD_MTLO, 32'h22);
        md_op(MD_DIV,  32'd5, 32'd0, 10, "div by 0");
        chk("div0 keep", {hi, lo}, 64'h00000011_00000022);
        md_op(MD_DIVU, 32'd9, 32'd0, 10, "divu by 0");
        md_op(MD_DIV,  32'h80000000, 32'hFFFFFFFF, 10, "div ovf");
        chk("ovf const", {hi, lo}, 64'h00000000_80000000);

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  ro;
            logic [31:0] rb;
            ro = 4'($urandom_range(1, 4));
            rb = (i == 5) ? 32'd0 : $urandom;
            if (i % 3 == 0) rb = 32'($urandom_range(1, 9));
            md_op(ro, $urandom, rb, (ro <= MD_MULTU) ? 5 : 10, $sformatf("rand%0d op%0d", i, ro));
        end

        // MF reads are combinational from op and independent of start.
        mt(MD_MTHI, 32'hDEADBEEF);
        op = MD_MFHI; #1;
        chk("mfhi hl_out", 64'(hl_out), 64'hDEADBEEF);
        op = MD_MFLO; #1;
        chk("mflo hl_out", 64'(hl_out), 64'(m_lo));
        op = MD_NONE; #1;
        chk("none hl_out", 64'(hl_out), 64'd0);
        op = 4'd12; #1;
        chk("op12 hl_out", 64'(hl_out), 64'd0);
        start = 1'b1; op = MD_MFHI; #1;
        chk("mfhi start hl_out", 64'(hl_out), 64'hDEADBEEF);
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
        @(negedge clk);
        chk("mfhi nochange", {hi, lo}, {32'hDEADBEEF, m_lo});

        // Start while busy is dropped; the next start is taken the cycle busy is low.
        @(posedge clk); #1;
        start = 1'b1; op = MD_MULT; a = 2; b = 3;
        sb_q.push_back(model(MD_MULT, 2, 3));
        busyv = '0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                start = 1'b1; op = MD_DIV; a = 9; b = 3;
            end else if (k == 5) begin
                start = 1'b1; op = MD_MULTU; a = 5; b = 7;
            end else begin
                start = 1'b0; op = MD_NONE;
            end
            @(negedge clk);
            busyv[k] = busy;
            if (k == 5) begin
                exp = sb_q.pop_front();
                chk("busy-start result", {hi, lo}, exp);
                chk("busy-start const", {hi, lo}, 64'd6);
                m_hi = exp[63:32]; m_lo = exp[31:0];
                sb_q.push_back(model(MD_MULTU, 5, 7));
            end
        end
        chk("busy-start busy pattern", 64'(busyv), 64'(7'b1011111));
        cyc = 1;
        @(negedge clk);
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk("reissue busy_cycles", 64'(cyc), 64'd5);
        exp = sb_q.pop_front();
        chk("reissue hi_lo", {hi, lo}, exp);
        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
